command_parse_and_encapsulate_mcnt: RTL and testbench

Parametrised multi-channel statistics/control register block for the network input process. It holds NUM_CH per-channel event counters, for example per-port packet-discard counts, plus one control register. Reads and writes arrive on the fixed-address configuration command bus. Read responses are encapsulated back onto the same bus format, using a 2-stage pipelined read path that accepts one command per cycle.

---
 rtl/command_parse_and_encapsulate_mcnt.sv | 136 +++++++++++++
 tb/tb_command_parse_and_encapsulate_mcnt.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_parse_and_encapsulate_mcnt.sv
// Multi-channel event counters plus a control register, accessed over the fixed-address
// command bus. Reads come back on the same bus format with a fixed 2-cycle latency.
module command_parse_and_encapsulate_mcnt #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [18:0] BASE_ADDR = 19'h0,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_CH-1:0]   iv_cnt_inc,
  input  logic [18:0]         iv_addr,
  input  logic                i_addr_fixed,
  input  logic [31:0]         iv_wdata,
  input  logic                i_wr,
  input  logic                i_rd,
  output logic                o_wr,
  output logic [18:0]         ov_addr,
  output logic                o_addr_fixed,
  output logic [31:0]         ov_rdata,
  output logic                o_frozen
);

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = AW + 1;
  localparam logic [OW-1:0]        LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [OW-1:0]        CTRL_OFF = OW'(NUM_CH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic                 freeze_q;
  logic                 freeze_d;

  logic [OW-1:0] off_c;
  logic          hit_c;
  logic          ctrl_sel_c;
  logic          wr_hit_c;
  logic          rd_hit_c;
  logic          clear_c;
  logic [DW-1:0] rd_data_c;

  logic          s1_vld;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;

  // One extra bit makes addresses below the base wrap to huge offsets, so a single
  // upper-bound compare covers both ends of the window.
  assign off_c      = {1'b0, iv_addr} - LO_ADDR;
  assign hit_c      = i_addr_fixed && (off_c <= CTRL_OFF);
  assign ctrl_sel_c = (off_c == CTRL_OFF);
  assign wr_hit_c   = hit_c && i_wr;
  assign rd_hit_c   = hit_c && i_rd && !i_wr;
  assign clear_c    = wr_hit_c && ctrl_sel_c && iv_wdata[1];

  // Counter next-state: clear-all beats a write, a write beats an increment.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear_c) begin
        cnt_d[k] = '0;
      end else if (wr_hit_c && (off_c == OW'(k))) begin
        cnt_d[k] = iv_wdata[CNT_WIDTH-1:0];
      end else if (iv_cnt_inc[k] && !freeze_q) begin
        if (cnt_q[k] != CNT_MAX) begin
          cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        end else if (!SATURATE) begin
          cnt_d[k] = '0;
        end
      end
    end
  end

  always_comb begin
    freeze_d = freeze_q;
    if (wr_hit_c && ctrl_sel_c) begin
      freeze_d = iv_wdata[0];
    end
  end

  // Read mux samples pre-update state so a read sees the value before same-cycle changes.
  always_comb begin
    rd_data_c = DW'(freeze_q);
    for (int k = 0; k < NUM_CH; k++) begin
      if (off_c == OW'(k)) begin
        rd_data_c = DW'(cnt_q[k]);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
      end
      freeze_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      freeze_q <= freeze_d;
    end
  end

  // Stage 1: capture hit, address and selected data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_vld  <= rd_hit_c;
      s1_addr <= rd_hit_c ? iv_addr : '0;
      s1_data <= rd_hit_c ? rd_data_c : '0;
    end
  end

  // Stage 2: encapsulate the response onto the bus; idle cycles drive all zeros.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr         <= 1'b0;
      ov_addr      <= '0;
      o_addr_fixed <= 1'b0;
      ov_rdata     <= '0;
    end else begin
      o_wr         <= s1_vld;
      ov_addr      <= s1_vld ? s1_addr : '0;
      o_addr_fixed <= s1_vld;
      ov_rdata     <= s1_vld ? s1_data : '0;
    end
  end

  assign o_frozen = freeze_q;

endmodule

// File: tb/tb_command_parse_and_encapsulate_mcnt.sv
// Scoreboard bench: two instances (saturating and wrapping, 4-bit counters) share stimulus;
// a reference model predicts responses and a monitor compares them as they appear.
module tb_command_parse_and_encapsulate_mcnt;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CW     = 4;
  localparam logic [18:0] BASE   = 19'h40;
  localparam int          CMAX   = (1 << CW) - 1;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] cnt_inc;
  logic [18:0]       addr;
  logic              addr_fixed;
  logic [31:0]       wdata;
  logic              wr;
  logic              rd;

  logic        wr_s, fx_s, frz_s;
  logic [18:0] addr_s;
  logic [31:0] rdata_s;
  logic        wr_w, fx_w, frz_w;
  logic [18:0] addr_w;
  logic [31:0] rdata_w;

  command_parse_and_encapsulate_mcnt #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CW), .BASE_ADDR(BASE), .SATURATE(1'b1)
  ) u_sat (
    .i_clk(clk), .i_rst(rst), .iv_cnt_inc(cnt_inc), .iv_addr(addr),
    .i_addr_fixed(addr_fixed), .iv_wdata(wdata), .i_wr(wr), .i_rd(rd),
    .o_wr(wr_s), .ov_addr(addr_s), .o_addr_fixed(fx_s), .ov_rdata(rdata_s),
    .o_frozen(frz_s)
  );

  command_parse_and_encapsulate_mcnt #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CW), .BASE_ADDR(BASE), .SATURATE(1'b0)
  ) u_wrap (
    .i_clk(clk), .i_rst(rst), .iv_cnt_inc(cnt_inc), .iv_addr(addr),
    .i_addr_fixed(addr_fixed), .iv_wdata(wdata), .i_wr(wr), .i_rd(rd),
    .o_wr(wr_w), .ov_addr(addr_w), .o_addr_fixed(fx_w), .ov_rdata(rdata_w),
    .o_frozen(frz_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [18:0] a;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];
  int   m_s [NUM_CH];
  int   m_w [NUM_CH];
  bit   m_frz;
  int   checks = 0;
  int   passes = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_s[k] = 0;
      m_w[k] = 0;
    end
    m_frz = 1'b0;
    q_s.delete();
    q_w.delete();
  endfunction

  // Compare one instance's bus against its queue head when the head is due.
  function automatic void mon(input bit w, input logic v, input logic [18:0] a,
                              input logic fx, input logic [31:0] d);
    exp_t  e;
    bit    have = 1'b0;
    string tag  = w ? "wrap" : "sat";
    if (w) begin
      if (q_w.size() > 0 && q_w[0].due <= cyc) begin
        e = q_w.pop_front();
        have = 1'b1;
      end
    end else begin
      if (q_s.size() > 0 && q_s[0].due <= cyc) begin
        e = q_s.pop_front();
        have = 1'b1;
      end
    end
    if (have) begin
      chk({tag, " resp_valid"}, 32'(v), 32'd1);
      chk({tag, " resp_latency"}, 32'(cyc), 32'(e.due));
      if (v) begin
        chk({tag, " resp_addr"}, 32'(a), 32'(e.a));
        chk({tag, " resp_fixed"}, 32'(fx), 32'd1);
        chk({tag, " resp_data"}, d, e.d);
      end
    end else begin
      chk({tag, " idle_valid"}, 32'(v), 32'd0);
      if (!v) begin
        chk({tag, " idle_bus"}, 32'(a) | 32'(fx) | d, 32'd0);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0, wr_s, addr_s, fx_s, rdata_s);
      mon(1'b1, wr_w, addr_w, fx_w, rdata_w);
    end
  end

  // Drive one cycle of stimulus, predict its effects, advance past the edge.
  task automatic step(input logic [NUM_CH-1:0] inc, input logic [18:0] ad, input logic fx,
                      input logic [31:0] wd, input logic w, input logic r);
    int   a, off;
    bit   hit, clr, nfrz;
    exp_t es, ew;
    cnt_inc = inc; addr = ad; addr_fixed = fx; wdata = wd; wr = w; rd = r;
    a   = int'(ad);
    off = a - int'(BASE);
    hit = fx && (a >= int'(BASE)) && (a <= int'(BASE) + NUM_CH);
    if (hit && r && !w) begin
      es.a = ad; ew.a = ad;
      es.due = cyc + 2; ew.due = cyc + 2;
      if (off == NUM_CH) begin
        es.d = 32'(m_frz); ew.d = 32'(m_frz);
      end else begin
        es.d = 32'(m_s[off]); ew.d = 32'(m_w[off]);
      end
      q_s.push_back(es);
      q_w.push_back(ew);
    end
    nfrz = m_frz;
    clr  = 1'b0;
    if (hit && w && off == NUM_CH) begin
      nfrz = wd[0];
      clr  = wd[1];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (clr) begin
        m_s[k] = 0; m_w[k] = 0;
      end else if (hit && w && off == k) begin
        m_s[k] = int'(wd) & CMAX; m_w[k] = int'(wd) & CMAX;
      end else if (inc[k] && !m_frz) begin
        m_s[k] = (m_s[k] == CMAX) ? CMAX : m_s[k] + 1;
        m_w[k] = (m_w[k] + 1) % (CMAX + 1);
      end
    end
    m_frz = nfrz;
    @(posedge clk);
    #1;
    chk("sat frozen", 32'(frz_s), 32'(m_frz));
    chk("wrap frozen", 32'(frz_w), 32'(m_frz));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_rd(input int off, input logic fx);
    step('0, BASE + 19'(off), fx, '0, 1'b0, 1'b1);
  endtask

  task automatic do_wr(input int off, input logic [31:0] d);
    step('0, BASE + 19'(off), 1'b1, d, 1'b1, 1'b0);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m, input int n);
    for (int i = 0; i < n; i++) step(m, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cnt_inc = '0; addr = '0; addr_fixed = 1'b0; wdata = '0; wr = 1'b0; rd = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset o_wr", 32'(wr_s) | 32'(wr_w), 32'd0);
    chk("reset bus", 32'(addr_s) | 32'(fx_s) | rdata_s | 32'(addr_w) | 32'(fx_w) | rdata_w, 32'd0);
    chk("reset frozen", 32'(frz_s) | 32'(frz_w), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [18:0] ra;
    logic [31:0] rw;
    do_reset();

    // Count five pulses on channel 2 and read it back.
    pulse(4'b0100, 5);
    do_rd(2, 1'b1);
    idle(3);

    // Drive 20 increments on channel 0: saturating instance sticks, wrapping one rolls over.
    pulse(4'b0001, 20);
    do_rd(0, 1'b1);
    idle(3);

    // Freeze discards increments; unfreeze resumes counting.
    do_wr(1, 32'd0);
    do_wr(NUM_CH, 32'h1);
    pulse(4'b0010, 10);
    do_rd(1, 1'b1);
    do_rd(NUM_CH, 1'b1);
    do_wr(NUM_CH, 32'h0);
    pulse(4'b0010, 3);
    do_rd(1, 1'b1);
    idle(3);

    // Clear-all overrides same-cycle increments on every channel.
    for (int k = 0; k < NUM_CH; k++) do_wr(k, 32'd7);
    step('1, BASE + 19'(NUM_CH), 1'b1, 32'h2, 1'b1, 1'b0);
    for (int k = 0; k <= NUM_CH; k++) do_rd(k, 1'b1);
    idle(3);

    // Back-to-back reads, then commands that must not respond.
    pulse(4'b1011, 2);
    for (int k = 0; k <= NUM_CH; k++) do_rd(k, 1'b1);
    do_rd(0, 1'b0);
    do_rd(NUM_CH + 1, 1'b1);
    step('0, BASE - 19'd1, 1'b1, '0, 1'b0, 1'b1);
    step('0, BASE + 19'd3, 1'b1, 32'd9, 1'b1, 1'b1);
    do_rd(3, 1'b1);
    idle(3);

    // Reset with a read in flight drops the response and clears everything.
    pulse(4'b1000, 4);
    do_rd(3, 1'b1);
    do_reset();
    for (int k = 0; k <= NUM_CH; k++) do_rd(k, 1'b1);
    idle(3);

    // Randomized traffic mixing increments, reads, writes and misses.
    for (int i = 0; i < 500; i++) begin
      r  = int'($urandom_range(0, 99));
      ra = BASE - 19'd1 + 19'($urandom_range(0, NUM_CH + 2));
      rw = $urandom;
      if (ra == BASE + 19'(NUM_CH)) begin
        rw[0] = ($urandom_range(0, 3) == 0);
        rw[1] = ($urandom_range(0, 3) == 0);
      end
      step(NUM_CH'($urandom), ra, ($urandom_range(0, 9) != 0), rw, (r < 15), (r >= 10 && r < 70));
    end
    for (int k = 0; k <= NUM_CH; k++) do_rd(k, 1'b1);
    idle(4);
    chk("drain sat queue", 32'(q_s.size()), 32'd0);
    chk("drain wrap queue", 32'(q_w.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
